// File: rtl/regex_ctx_pkg.sv
// Shared definitions for the per-stream regex context manager:
// the context FSM encoding and the default parameter values.
package regex_ctx_pkg;

    localparam int DEF_STATE_W  = 11;
    localparam int DEF_STREAM_W = 6;
    localparam int DEF_COUNT_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_SAVE   = 2'd3
    } ctx_state_e;

endpackage

// File: rtl/regex_ctx_mem.sv
// Context storage: one saved DFA state word per stream.
// Single write port, asynchronous read, so it maps onto distributed RAM.
// Contents are never reset; the owner masks stale entries with valid bits.
module regex_ctx_mem #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 11
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Write port: store the matcher state at the end of a packet
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/regex_stream_ctx.sv
// Per-stream context switcher for an external DFA matcher.
// On packet start the stream's saved state is loaded into the matcher,
// payload bytes are forwarded while the packet is active, and at packet
// end the matcher state is written back and the match counter updated.
module regex_stream_ctx
    import regex_ctx_pkg::*;
#(
    parameter int STATE_W  = DEF_STATE_W,
    parameter int STREAM_W = DEF_STREAM_W,
    parameter int COUNT_W  = DEF_COUNT_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sop,
    input  logic [STREAM_W-1:0] stream_id,
    input  logic                enable,
    input  logic [7:0]          char_in,
    input  logic                char_in_vld,
    input  logic                eop,
    input  logic                clear_all,
    output logic [7:0]          dfa_char,
    output logic                dfa_char_vld,
    output logic [STATE_W-1:0]  dfa_state_in,
    output logic                dfa_state_in_vld,
    input  logic [STATE_W-1:0]  dfa_state_out,
    input  logic                dfa_accept,
    output logic [COUNT_W-1:0]  count,
    output logic                fired,
    output logic                busy,
    output logic                err_proto
);

    localparam int NUM_STREAMS = 2**STREAM_W;
    localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};

    ctx_state_e              state_q;
    ctx_state_e              state_d;
    logic [STREAM_W-1:0]     sid_q;
    logic                    en_q;
    logic [NUM_STREAMS-1:0]  valid_q;
    logic [STATE_W-1:0]      rd_data;
    logic                    mem_we;
    logic                    proto_viol;
    logic [COUNT_W-1:0]      count_q;
    logic                    fired_q;
    logic                    err_q;
    logic                    hit;

    regex_ctx_mem #(
        .ADDR_W (STREAM_W),
        .DATA_W (STATE_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (sid_q),
        .wdata (dfa_state_out),
        .raddr (sid_q),
        .rdata (rd_data)
    );

    assign hit       = fired_q | dfa_accept;
    assign count     = count_q;
    assign fired     = fired_q;
    assign err_proto = err_q;
    assign busy      = (state_q != ST_IDLE);

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, matcher interface and protocol checks
    always_comb begin
        state_d          = state_q;
        dfa_char         = 8'h00;
        dfa_char_vld     = 1'b0;
        dfa_state_in     = '0;
        dfa_state_in_vld = 1'b0;
        mem_we           = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sop) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                dfa_state_in_vld = 1'b1;
                dfa_state_in     = valid_q[sid_q] ? rd_data : '0;
                state_d          = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                dfa_char     = char_in;
                dfa_char_vld = char_in_vld;
                if (eop) begin
                    state_d = ST_SAVE;
                end
            end
            ST_SAVE: begin
                mem_we  = en_q & rst_n;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        proto_viol = (sop && (state_q != ST_IDLE))
                   || (eop && (state_q != ST_ACTIVE))
                   || (char_in_vld && (state_q != ST_ACTIVE));
    end

    // Capture the stream id at packet start and the enable at packet end
    always_ff @(posedge clk) begin
        if ((state_q == ST_IDLE) && sop) begin
            sid_q <= stream_id;
        end
        if ((state_q == ST_ACTIVE) && eop) begin
            en_q <= enable;
        end
    end

    // Valid bits: a global clear beats a write-back to the same cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (clear_all) begin
            valid_q <= '0;
        end else if (mem_we) begin
            valid_q[sid_q] <= 1'b1;
        end
    end

    // Per-packet match flag and saturating count of matching packets
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fired_q <= 1'b0;
            count_q <= '0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    fired_q <= 1'b0;
                end
                ST_ACTIVE: begin
                    if (dfa_accept) begin
                        fired_q <= 1'b1;
                    end
                end
                ST_SAVE: begin
                    if (en_q) begin
                        fired_q <= hit;
                        if (hit && (count_q != COUNT_MAX)) begin
                            count_q <= count_q + COUNT_W'(1);
                        end
                    end else begin
                        fired_q <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Sticky protocol-violation flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (proto_viol) begin
            err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_regex_stream_ctx.sv
// Bench for regex_stream_ctx: a simple shift-register DFA stands in for the
// matcher, and a stream-level model tracks saved states, valid bits and
// match counts. A second instance with a 4-bit counter checks saturation.
module tb_regex_stream_ctx;

    localparam logic [7:0] ACC_CHAR = 8'hEE;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sop = 1'b0;
    logic [5:0]  stream_id = '0;
    logic        enable = 1'b0;
    logic [7:0]  char_in = '0;
    logic        char_in_vld = 1'b0;
    logic        eop = 1'b0;
    logic        clear_all = 1'b0;

    logic [7:0]  dfa_char;
    logic        dfa_char_vld;
    logic [10:0] dfa_state_in;
    logic        dfa_state_in_vld;
    logic [15:0] count;
    logic        fired;
    logic        busy;
    logic        err_proto;

    logic [7:0]  s_dfa_char;
    logic        s_dfa_char_vld;
    logic [10:0] s_dfa_state_in;
    logic        s_dfa_state_in_vld;
    logic [3:0]  s_count;
    logic        s_fired;
    logic        s_busy;
    logic        s_err_proto;

    logic [10:0] m_state = '0;
    logic        m_accept = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    logic [10:0] mdl_mem [64];
    bit          mdl_valid [64];
    int          mdl_cnt;
    int          mdl_sat;
    bit          mdl_fired;
    logic [7:0]  pkt [8];

    always #5 clk = ~clk;

    regex_stream_ctx dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .sop              (sop),
        .stream_id        (stream_id),
        .enable           (enable),
        .char_in          (char_in),
        .char_in_vld      (char_in_vld),
        .eop              (eop),
        .clear_all        (clear_all),
        .dfa_char         (dfa_char),
        .dfa_char_vld     (dfa_char_vld),
        .dfa_state_in     (dfa_state_in),
        .dfa_state_in_vld (dfa_state_in_vld),
        .dfa_state_out    (m_state),
        .dfa_accept       (m_accept),
        .count            (count),
        .fired            (fired),
        .busy             (busy),
        .err_proto        (err_proto)
    );

    regex_stream_ctx #(.COUNT_W(4)) dut_sat (
        .clk              (clk),
        .rst_n            (rst_n),
        .sop              (sop),
        .stream_id        (stream_id),
        .enable           (enable),
        .char_in          (char_in),
        .char_in_vld      (char_in_vld),
        .eop              (eop),
        .clear_all        (clear_all),
        .dfa_char         (s_dfa_char),
        .dfa_char_vld     (s_dfa_char_vld),
        .dfa_state_in     (s_dfa_state_in),
        .dfa_state_in_vld (s_dfa_state_in_vld),
        .dfa_state_out    (m_state),
        .dfa_accept       (m_accept),
        .count            (s_count),
        .fired            (s_fired),
        .busy             (s_busy),
        .err_proto        (s_err_proto)
    );

    // Stand-in matcher: state shifts in each byte, accept one cycle after ACC_CHAR
    always @(posedge clk) begin
        m_accept <= 1'b0;
        if (dfa_state_in_vld) begin
            m_state <= dfa_state_in;
        end else if (dfa_char_vld) begin
            m_state  <= {m_state[2:0], dfa_char};
            m_accept <= (dfa_char == ACC_CHAR);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic [5:0] id, input logic en,
                                 input logic [7:0] ch, input logic chv, input logic e,
                                 input logic clr);
        @(negedge clk);
        sop         = s;
        stream_id   = id;
        enable      = en;
        char_in     = ch;
        char_in_vld = chv;
        eop         = e;
        clear_all   = clr;
        #1;
    endtask

    task automatic modelClear();
        for (int i = 0; i < 64; i++) mdl_valid[i] = 1'b0;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0;
        sop = 1'b0; char_in_vld = 1'b0; eop = 1'b0; clear_all = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        modelClear();
        mdl_cnt   = 0;
        mdl_sat   = 0;
        mdl_fired = 1'b0;
    endtask

    task automatic countMatch();
        if (mdl_cnt < 65535) mdl_cnt++;
        if (mdl_sat < 15) mdl_sat++;
    endtask

    // One full packet: sop, LOAD, n bytes (eop on the last), SAVE
    task automatic runPacket(input logic [5:0] sid, input bit en, input int n, input bit clr_save);
        logic [10:0] exp_load;
        logic [10:0] st;
        bit          hitq;
        applyStimulus(1, sid, 0, 8'h00, 0, 0, 0);
        checkOutput("busy_idle", busy, 0);
        checkOutput("fired_prev", fired, mdl_fired);
        checkOutput("count", count, mdl_cnt);
        checkOutput("count_sat", s_count, mdl_sat);
        exp_load = mdl_valid[sid] ? mdl_mem[sid] : 11'h000;
        applyStimulus(0, 0, 0, 8'h00, 0, 0, 0);
        checkOutput("load_vld", dfa_state_in_vld, 1);
        checkOutput("load_state", dfa_state_in, exp_load);
        st   = exp_load;
        hitq = 1'b0;
        for (int i = 0; i < n; i++) begin
            applyStimulus(0, 0, en, pkt[i], 1, (i == n - 1), 0);
            checkOutput("char_vld", dfa_char_vld, 1);
            checkOutput("char", dfa_char, pkt[i]);
            st = {st[2:0], pkt[i]};
            if (pkt[i] == ACC_CHAR) hitq = 1'b1;
        end
        applyStimulus(0, 0, 0, 8'h00, 0, 0, clr_save);
        checkOutput("busy_save", busy, 1);
        if (en) begin
            mdl_mem[sid]   = st;
            mdl_valid[sid] = 1'b1;
            if (hitq) countMatch();
        end
        mdl_fired = en & hitq;
        if (clr_save) modelClear();
    endtask

    initial begin
        logic [10:0] st2;
        int          gap;
        bit          clr;

        // Reset state
        doReset();
        applyStimulus(0, 0, 0, 8'h00, 0, 0, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_count", count, 0);
        checkOutput("rst_fired", fired, 0);
        checkOutput("rst_err", err_proto, 0);
        checkOutput("rst_load_vld", dfa_state_in_vld, 0);
        checkOutput("rst_char_vld", dfa_char_vld, 0);

        // New stream 5 loads zero, saves 0x2A3; reload restores it
        pkt[0] = 8'h02; pkt[1] = 8'hA3;
        runPacket(6'd5, 1, 2, 0);
        pkt[0] = 8'h11;
        runPacket(6'd5, 1, 1, 0);

        // Match counting with enable, then without
        pkt[0] = 8'h01; pkt[1] = ACC_CHAR; pkt[2] = 8'h02;
        runPacket(6'd9, 1, 3, 0);
        pkt[0] = ACC_CHAR;
        runPacket(6'd9, 0, 1, 0);
        pkt[0] = 8'h40;
        runPacket(6'd9, 1, 1, 0);

        // clear_all coincident with SAVE on stream 3
        pkt[0] = 8'h55; pkt[1] = 8'h66;
        runPacket(6'd3, 1, 2, 1);
        pkt[0] = 8'h77;
        runPacket(6'd3, 1, 1, 0);

        // Randomized packets, gaps and clears
        for (int k = 0; k < 40; k++) begin
            int n;
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++)
                pkt[i] = ($urandom_range(0, 3) == 0) ? ACC_CHAR : 8'($urandom_range(0, 255));
            runPacket(6'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0), n,
                      ($urandom_range(0, 15) == 0));
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                clr = ($urandom_range(0, 15) == 0);
                applyStimulus(0, 0, 0, 8'h00, 0, 0, clr);
                if (clr) modelClear();
            end
        end

        // Saturation of the 4-bit counter
        for (int k = 0; k < 20; k++) begin
            pkt[0] = ACC_CHAR; pkt[1] = 8'($urandom_range(0, 255));
            runPacket(6'($urandom_range(10, 20)), 1, 2, 0);
        end
        applyStimulus(0, 0, 0, 8'h00, 0, 0, 0);
        checkOutput("sat_count", s_count, mdl_sat);
        checkOutput("main_count", count, mdl_cnt);
        checkOutput("fired_end", fired, mdl_fired);
        checkOutput("err_clean", err_proto, 0);

        // char_in_vld in IDLE is dropped and flagged
        applyStimulus(0, 0, 0, 8'h99, 1, 0, 0);
        checkOutput("idle_char_drop", dfa_char_vld, 0);
        applyStimulus(0, 0, 0, 8'h00, 0, 0, 0);
        checkOutput("err_idle_char", err_proto, 1);

        // sop during ACTIVE is ignored; packet stays on stream 2
        applyStimulus(1, 6'd2, 0, 8'h00, 0, 0, 0);
        st2 = mdl_valid[2] ? mdl_mem[2] : 11'h000;
        applyStimulus(0, 0, 0, 8'h00, 0, 0, 0);
        checkOutput("p_load_state", dfa_state_in, st2);
        applyStimulus(1, 6'd6, 1, 8'h33, 1, 0, 0);
        checkOutput("p_char", dfa_char, 8'h33);
        applyStimulus(0, 0, 1, 8'h44, 1, 1, 0);
        checkOutput("p_no_reload", dfa_state_in_vld, 0);
        checkOutput("p_busy", busy, 1);
        applyStimulus(0, 0, 0, 8'h00, 0, 0, 0);
        st2 = {st2[2:0], 8'h33};
        st2 = {st2[2:0], 8'h44};
        mdl_mem[2]   = st2;
        mdl_valid[2] = 1'b1;
        mdl_fired    = 1'b0;
        applyStimulus(0, 0, 0, 8'h00, 0, 0, 0);
        checkOutput("err_sop_active", err_proto, 1);
        pkt[0] = 8'h12;
        runPacket(6'd2, 1, 1, 0);
        runPacket(6'd6, 0, 1, 0);
        applyStimulus(0, 0, 0, 8'h00, 0, 0, 0);
        checkOutput("err_sticky", err_proto, 1);

        // Reset clears the flag and every valid bit
        doReset();
        applyStimulus(0, 0, 0, 8'h00, 0, 0, 0);
        checkOutput("err_after_rst", err_proto, 0);
        runPacket(6'd2, 1, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/regex_stream_ctx.md
REGEX_STREAM_CTX -- requirements
Module: regex_stream_ctx

Interface
REQ-001 Parameter STATE_W, default 11, width of the DFA state word saved per stream.
REQ-002 Parameter STREAM_W, default 6, stream-id width; NUM_STREAMS = 2**STREAM_W contexts.
REQ-003 Parameter COUNT_W, default 16, width of the match counter.
REQ-004 clk  in  1  clock; all logic on rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 sop  in  1  packet start; samples stream_id.
REQ-007 stream_id  in  STREAM_W  stream of the packet.
REQ-008 enable  in  1  regex enabled for this stream; sampled at eop.
REQ-009 char_in / char_in_vld  in  8 / 1  payload byte and qualifier.
REQ-010 eop  in  1  packet end.
REQ-011 clear_all  in  1  invalidates all stored contexts.
REQ-012 dfa_char / dfa_char_vld  out  8 / 1  byte to matcher.
REQ-013 dfa_state_in / dfa_state_in_vld  out  STATE_W / 1  state load to matcher.
REQ-014 dfa_state_out / dfa_accept  in  STATE_W / 1  matcher state and accept; 1-cycle latency after dfa_char_vld.
REQ-015 count  out  COUNT_W  packets with at least one match.
REQ-016 fired  out  1  current packet has matched.
REQ-017 busy  out  1  FSM not IDLE.
REQ-018 err_proto  out  1  sticky protocol-violation flag.

Function
REQ-019 FSM states IDLE, LOAD, ACTIVE, SAVE; busy = (state != IDLE).
REQ-020 IDLE + sop: latch stream_id into sid_q; go to LOAD.
REQ-021 LOAD, one cycle: dfa_state_in_vld=1; dfa_state_in = ctx_mem[sid_q] if valid[sid_q], else 0; fired cleared; go to ACTIVE.
REQ-022 ACTIVE: dfa_char/dfa_char_vld = char_in/char_in_vld, combinational pass-through; char_in_vld in IDLE/LOAD/SAVE is dropped and sets err_proto.
REQ-023 fired sets when dfa_accept=1 in ACTIVE or SAVE; held until next LOAD.
REQ-024 ACTIVE + eop: latch enable into en_q; go to SAVE; a char_in_vld in the same cycle is forwarded.
REQ-025 SAVE, one cycle, when en_q=1: ctx_mem[sid_q] <= dfa_state_out; valid[sid_q] <= 1; count += (fired | dfa_accept), saturating at 2**COUNT_W-1.
REQ-026 SAVE, when en_q=0: no memory or count update; fired cleared; go to IDLE.
REQ-027 sop outside IDLE is ignored and sets err_proto; eop outside ACTIVE is ignored and sets err_proto.
REQ-028 clear_all zeroes every valid bit next cycle. If it coincides with a SAVE write, clear_all wins for all streams, including sid_q.
REQ-029 Back-to-back packets: sop may assert in the cycle after SAVE, giving a minimum of 3 overhead cycles per packet.
REQ-030 A stream written in SAVE and loaded in the immediately following LOAD returns the newly written state.

Reset
REQ-031 Reset gives: FSM=IDLE, count=0, fired=0, err_proto=0, all valid bits 0, dfa_state_in_vld=0, dfa_char_vld=0.
REQ-032 ctx_mem contents are not reset; the valid bits mask them.
REQ-033 Reset mid-packet abandons the packet with no memory write.

Structure
REQ-034 Shared package regex_ctx_pkg holds the FSM state enum and the default values of STATE_W, STREAM_W and COUNT_W.
REQ-035 Sub-module regex_ctx_mem: NUM_STREAMS x STATE_W memory, 1 write port, asynchronous read, synthesisable to distributed RAM; valid bits live outside it in flops.
REQ-036 The DFA matcher is instantiated outside this block.

Verification
REQ-037 New stream: reset; sop with stream_id=5 -> dfa_state_in_vld=1 with dfa_state_in=0 the cycle after sop.
REQ-038 Restore: stream 5 saved with state 0x2A3 and enable=1; a later sop on stream 5 -> dfa_state_in=0x2A3 in LOAD.
REQ-039 Match count: accept pulse mid-packet, eop with enable=1 -> fired=1, count 0->1; repeat with enable=0 -> count stays 1 and ctx_mem is unchanged.
REQ-040 Saturation: COUNT_W=4 with 20 matching packets -> count holds at 15.
REQ-041 Protocol: sop during ACTIVE, and char_in_vld in IDLE -> both ignored, err_proto=1 until reset.
REQ-042 clear_all coincident with SAVE on stream 3 -> next sop on stream 3 loads state 0.
